// File: rtl/jisp_pkg.sv
// Shared types and sizing helpers for the JISP front-end control blocks.
package jisp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE,
    ST_FLUSH
  } frame_state_e;

  // 4:2:0 MCU = four luma blocks plus one Cb and one Cr block.
  localparam int BLK_PER_MCU = 6;

  function automatic int blk_cnt_width(input int x_size, input int y_size);
    return $clog2(BLK_PER_MCU * (x_size / 16 + 1) * (y_size / 16 + 1));
  endfunction

endpackage

// File: rtl/jisp_drain_wdt.sv
// Loadable down-counter watchdog: raises o_timeout after TIMEOUT enabled
// cycles without a reload.
module jisp_drain_wdt #(
  parameter  int TIMEOUT = 65535,
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_timeout
);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_timeout = i_en && !i_load && (r_cnt == '0);

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer for the JISP front end: latches image size, gates camera
// pixels to start-of-frame, counts emitted 8x8 blocks and handles errors.
module jpeg_frame_ctrl
  import jisp_pkg::*;
#(
  parameter  int SENSOR_X_SIZE = 720,
  parameter  int SENSOR_Y_SIZE = 720,
  parameter  int DRAIN_TIMEOUT = 65535,
  localparam int XW            = $clog2(SENSOR_X_SIZE),
  localparam int YW            = $clog2(SENSOR_Y_SIZE),
  localparam int BLK_W         = blk_cnt_width(SENSOR_X_SIZE, SENSOR_Y_SIZE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [XW-1:0]    x_size_m1_cfg,
  input  logic [YW-1:0]    y_size_m1_cfg,
  output logic [XW-1:0]    x_size_m1,
  output logic [YW-1:0]    y_size_m1,
  input  logic             yuvrgb_in_valid0,
  input  logic             yuvrgb_in_hold,
  input  logic [XW-1:0]    yuvrgb_in_pixel_count,
  input  logic [YW-1:0]    yuvrgb_in_line_count,
  input  logic             eof_in,
  output logic             pix_gate,
  input  logic             di_valid,
  input  logic             di_hold,
  input  logic [2:0]       di_cnt,
  output logic             dp_clr,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_short,
  output logic             err_timeout,
  output logic [BLK_W-1:0] blk_count
);

  frame_state_e     r_state;
  logic [XW-1:0]    r_x_size_m1;
  logic [YW-1:0]    r_y_size_m1;
  logic [XW-1:0]    r_last_x;
  logic [YW-1:0]    r_last_y;
  logic [BLK_W-1:0] r_blk_total;
  logic [BLK_W-1:0] r_blk_count;
  logic             r_busy;
  logic             r_done;
  logic             r_flush_pulse;
  logic             r_err_short;
  logic             r_err_timeout;

  logic             w_sof;
  logic             w_pix_accept;
  logic             w_blk_done;
  logic             w_final_blk;
  logic             w_count_en;
  logic             w_start_ok;
  logic [XW-1:0]    w_last_x;
  logic [YW-1:0]    w_last_y;
  logic             w_short;
  logic [BLK_W-1:0] w_mcu_cols;
  logic [BLK_W-1:0] w_mcu_rows;
  logic             w_wdt_load;
  logic             w_wdt_en;
  logic             w_timeout;

  assign w_sof = yuvrgb_in_valid0 && (yuvrgb_in_pixel_count == '0) && (yuvrgb_in_line_count == '0);
  assign pix_gate     = (r_state == ST_CAPTURE) || ((r_state == ST_ARM) && w_sof);
  assign w_pix_accept = yuvrgb_in_valid0 && pix_gate && !yuvrgb_in_hold;
  assign w_start_ok   = (r_state == ST_IDLE) && start && !abort;

  assign w_blk_done  = di_valid && !di_hold && (di_cnt == 3'd7);
  assign w_final_blk = w_blk_done && (r_blk_count == r_blk_total - BLK_W'(1));
  assign w_count_en  = ((r_state == ST_CAPTURE) || (r_state == ST_DRAIN)) && w_blk_done
                       && !abort && (r_blk_count < r_blk_total);

  // The pixel accepted on the eof cycle itself counts as the last pixel.
  assign w_last_x = w_pix_accept ? yuvrgb_in_pixel_count : r_last_x;
  assign w_last_y = w_pix_accept ? yuvrgb_in_line_count : r_last_y;
  assign w_short  = (w_last_x != r_x_size_m1) || (w_last_y != r_y_size_m1);

  assign w_mcu_cols = BLK_W'(r_x_size_m1 >> 4) + BLK_W'(1);
  assign w_mcu_rows = BLK_W'(r_y_size_m1 >> 4) + BLK_W'(1);

  assign w_wdt_en   = (r_state == ST_DRAIN);
  assign w_wdt_load = ((r_state == ST_CAPTURE) && eof_in && !abort)
                   || ((r_state == ST_DRAIN) && w_blk_done);

  jisp_drain_wdt #(
    .TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_wdt (
    .clk       (clk),
    .rst_n     (resetn),
    .i_load    (w_wdt_load),
    .i_en      (w_wdt_en),
    .o_timeout (w_timeout)
  );

  // Sizes are frozen while busy, so the product settles during ARM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_blk_total <= '0;
    end else begin
      r_blk_total <= BLK_W'(BLK_PER_MCU) * w_mcu_cols * w_mcu_rows;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_x <= '0;
      r_last_y <= '0;
    end else if (w_start_ok) begin
      r_last_x <= '0;
      r_last_y <= '0;
    end else if (w_pix_accept) begin
      r_last_x <= yuvrgb_in_pixel_count;
      r_last_y <= yuvrgb_in_line_count;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_x_size_m1   <= '0;
      r_y_size_m1   <= '0;
      r_blk_count   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_flush_pulse <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_flush_pulse <= 1'b0;
      if (w_count_en) r_blk_count <= r_blk_count + BLK_W'(1);

      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_x_size_m1   <= x_size_m1_cfg;
            r_y_size_m1   <= y_size_m1_cfg;
            r_blk_count   <= '0;
            r_err_short   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (abort) begin
            r_busy        <= 1'b0;
            r_flush_pulse <= 1'b1;
            r_state       <= ST_FLUSH;
          end else if (w_sof && !yuvrgb_in_hold) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            r_busy        <= 1'b0;
            r_flush_pulse <= 1'b1;
            r_state       <= ST_FLUSH;
          end else if (eof_in) begin
            if (w_short) r_err_short <= 1'b1;
            if (w_final_blk) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            r_busy        <= 1'b0;
            r_flush_pulse <= 1'b1;
            r_state       <= ST_FLUSH;
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_flush_pulse <= 1'b1;
            r_state       <= ST_FLUSH;
          end else if (w_final_blk) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        ST_FLUSH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign x_size_m1   = r_x_size_m1;
  assign y_size_m1   = r_y_size_m1;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_flush_pulse;
  assign dp_clr      = r_flush_pulse;
  assign err_short   = r_err_short;
  assign err_timeout = r_err_timeout;
  assign blk_count   = r_blk_count;

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Randomized bench for jpeg_frame_ctrl with a cycle-level behavioural model
// and a few hand-computed expectations for the main scenarios.
module tb_jpeg_frame_ctrl;

  localparam int TB_TIMEOUT = 3000;
  localparam int P_IDLE = 0, P_ARM = 1, P_CAP = 2, P_DRAIN = 3, P_DONE = 4, P_FLUSH = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [9:0]  x_size_m1_cfg = '0, y_size_m1_cfg = '0;
  logic [9:0]  x_size_m1, y_size_m1;
  logic        yuvrgb_in_valid0 = 1'b0, yuvrgb_in_hold = 1'b0;
  logic [9:0]  yuvrgb_in_pixel_count = '0, yuvrgb_in_line_count = '0;
  logic        eof_in = 1'b0;
  logic        pix_gate;
  logic        di_valid = 1'b0, di_hold = 1'b0;
  logic [2:0]  di_cnt = '0;
  logic        dp_clr, busy, done, aborted, err_short, err_timeout;
  logic [13:0] blk_count;

  int total_cnt = 0;
  int bad_cnt   = 0;

  jpeg_frame_ctrl #(
    .SENSOR_X_SIZE (720),
    .SENSOR_Y_SIZE (720),
    .DRAIN_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .start                 (start),
    .abort                 (abort),
    .x_size_m1_cfg         (x_size_m1_cfg),
    .y_size_m1_cfg         (y_size_m1_cfg),
    .x_size_m1             (x_size_m1),
    .y_size_m1             (y_size_m1),
    .yuvrgb_in_valid0      (yuvrgb_in_valid0),
    .yuvrgb_in_hold        (yuvrgb_in_hold),
    .yuvrgb_in_pixel_count (yuvrgb_in_pixel_count),
    .yuvrgb_in_line_count  (yuvrgb_in_line_count),
    .eof_in                (eof_in),
    .pix_gate              (pix_gate),
    .di_valid              (di_valid),
    .di_hold               (di_hold),
    .di_cnt                (di_cnt),
    .dp_clr                (dp_clr),
    .busy                  (busy),
    .done                  (done),
    .aborted               (aborted),
    .err_short             (err_short),
    .err_timeout           (err_timeout),
    .blk_count             (blk_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      if (bad_cnt >= 200) begin
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph = P_IDLE, m_x = 0, m_y = 0, m_total = 0, m_cnt = 0;
  int m_lastx = 0, m_lasty = 0, m_idle = 0;
  bit m_short = 0, m_tmo = 0;

  task automatic model_step();
    bit bd, sof, acc;
    bd  = di_valid && !di_hold && (di_cnt == 3'd7);
    sof = yuvrgb_in_valid0 && (yuvrgb_in_pixel_count == 0) && (yuvrgb_in_line_count == 0);
    acc = yuvrgb_in_valid0 && !yuvrgb_in_hold && (m_ph == P_CAP || (m_ph == P_ARM && sof));
    if (acc) begin
      m_lastx = int'(yuvrgb_in_pixel_count);
      m_lasty = int'(yuvrgb_in_line_count);
    end
    case (m_ph)
      P_IDLE: if (start && !abort) begin
        m_x = int'(x_size_m1_cfg);
        m_y = int'(y_size_m1_cfg);
        m_total = 6 * (m_x / 16 + 1) * (m_y / 16 + 1);
        m_cnt = 0; m_short = 0; m_tmo = 0; m_lastx = 0; m_lasty = 0;
        m_ph = P_ARM;
      end
      P_ARM: if (abort) m_ph = P_FLUSH;
             else if (sof && !yuvrgb_in_hold) m_ph = P_CAP;
      P_CAP: if (abort) m_ph = P_FLUSH;
             else begin
               if (eof_in) begin
                 if (m_lastx != m_x || m_lasty != m_y) m_short = 1;
                 m_ph = (bd && m_cnt == m_total - 1) ? P_DONE : P_DRAIN;
                 m_idle = 0;
               end
               if (bd && m_cnt < m_total) m_cnt++;
             end
      P_DRAIN: if (abort) m_ph = P_FLUSH;
               else if (bd) begin
                 if (m_cnt == m_total - 1) m_ph = P_DONE;
                 if (m_cnt < m_total) m_cnt++;
                 m_idle = 0;
               end else begin
                 m_idle++;
                 if (m_idle >= TB_TIMEOUT) begin
                   m_tmo = 1;
                   m_ph = P_FLUSH;
                 end
               end
      default: m_ph = P_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph = P_IDLE; m_x = 0; m_y = 0; m_total = 0; m_cnt = 0;
      m_lastx = 0; m_lasty = 0; m_idle = 0; m_short = 0; m_tmo = 0;
    end else begin
      model_step();
    end
  end

  bit c_sof, c_busy;
  always @(negedge clk) begin
    c_sof  = yuvrgb_in_valid0 && (yuvrgb_in_pixel_count == 0) && (yuvrgb_in_line_count == 0);
    c_busy = (m_ph == P_ARM) || (m_ph == P_CAP) || (m_ph == P_DRAIN);
    check("busy", busy, c_busy);
    check("done", done, m_ph == P_DONE);
    check("aborted", aborted, m_ph == P_FLUSH);
    check("dp_clr", dp_clr, m_ph == P_FLUSH);
    check("err_short", err_short, m_short);
    check("err_timeout", err_timeout, m_tmo);
    check("blk_count", blk_count, m_cnt);
    check("x_size_m1", x_size_m1, m_x);
    check("y_size_m1", y_size_m1, m_y);
    check("pix_gate", pix_gate, (m_ph == P_CAP) || (m_ph == P_ARM && c_sof));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    start = 0; abort = 0; eof_in = 0;
    yuvrgb_in_valid0 = 0; yuvrgb_in_hold = 0;
    di_valid = 0; di_hold = 0; di_cnt = 0;
  endtask

  task automatic start_frame(input int x, input int y);
    x_size_m1_cfg = 10'(x);
    y_size_m1_cfg = 10'(y);
    start = 1;
    cyc();
  endtask

  task automatic pixel(input int x, input int y, input bit hold, input bit eof);
    yuvrgb_in_valid0 = 1;
    yuvrgb_in_pixel_count = 10'(x);
    yuvrgb_in_line_count = 10'(y);
    yuvrgb_in_hold = hold;
    eof_in = eof;
    cyc();
  endtask

  // Completes n blocks with random pacing; non-origin pixel noise rides along.
  task automatic run_blocks(input int n);
    int got = 0;
    while (got < n) begin
      di_valid = ($urandom_range(0, 15) != 0);
      di_hold  = ($urandom_range(0, 7) == 0);
      di_cnt   = ($urandom_range(0, 7) != 0) ? 3'd7 : 3'($urandom_range(0, 6));
      if (di_valid && !di_hold && di_cnt == 3'd7) got++;
      yuvrgb_in_valid0 = 1'($urandom_range(0, 1));
      yuvrgb_in_pixel_count = 10'($urandom_range(1, 700));
      yuvrgb_in_line_count = 10'($urandom_range(1, 700));
      yuvrgb_in_hold = ($urandom_range(0, 3) == 0);
      cyc();
    end
  endtask

  task automatic last_block(input bit with_abort);
    di_valid = 1; di_hold = 0; di_cnt = 3'd7; abort = with_abort;
    cyc();
  endtask

  task automatic full_frame(input bit abort_last);
    start_frame(719, 719);
    pixel(0, 0, 0, 0);
    run_blocks(12149);
    pixel(719, 719, 0, 1);
    last_block(abort_last);
    @(negedge clk);
    if (abort_last) begin
      check("abort_last_aborted", aborted, 1);
      check("abort_last_done", done, 0);
      check("abort_last_count", blk_count, 12149);
    end else begin
      check("full_done", done, 1);
      check("full_busy", busy, 0);
      check("full_count", blk_count, 12150);
      check("full_err_short", err_short, 0);
      check("full_err_timeout", err_timeout, 0);
    end
    cyc();
    @(negedge clk);
    check("pulse_one_cycle", done | aborted, 0);
    check("count_holds", blk_count, abort_last ? 12149 : 12150);
  endtask

  initial begin
    #20000000;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1);
  end

  initial begin
    int n_ab, n_dn, n_clr;
    #2 resetn = 0;
    repeat (3) cyc();
    check("reset_busy", busy, 0);
    check("reset_count", blk_count, 0);
    resetn = 1;
    cyc();

    // 720x720 full frame
    full_frame(0);

    // 100x36 non-aligned, sof held once, start/cfg change while busy ignored
    start_frame(99, 35);
    check("model_total_100x36", m_total, 126);
    pixel(0, 0, 1, 0);
    pixel(0, 0, 0, 0);
    x_size_m1_cfg = 10'd5;
    start = 1;
    cyc();
    run_blocks(50);
    pixel(99, 35, 0, 1);
    run_blocks(75);
    last_block(0);
    @(negedge clk);
    check("f100_done", done, 1);
    check("f100_count", blk_count, 126);
    check("f100_xsize", x_size_m1, 99);
    cyc();

    // start mid-frame: lines 5+ must not pass the gate
    start_frame(99, 35);
    for (int l = 5; l < 12; l++) begin
      yuvrgb_in_valid0 = 1;
      yuvrgb_in_pixel_count = 10'($urandom_range(0, 99));
      yuvrgb_in_line_count = 10'(l);
      #1 check("midframe_gate", pix_gate, 0);
      cyc();
    end
    yuvrgb_in_valid0 = 1;
    yuvrgb_in_pixel_count = 0;
    yuvrgb_in_line_count = 0;
    #1 check("sof_gate", pix_gate, 1);
    cyc();
    run_blocks(10);
    pixel(99, 35, 0, 1);
    run_blocks(115);
    last_block(0);
    @(negedge clk);
    check("mid_done", done, 1);
    check("mid_count", blk_count, 126);
    cyc();

    // short frame then drain timeout
    start_frame(719, 719);
    pixel(0, 0, 0, 0);
    pixel(719, 400, 0, 1);
    @(negedge clk);
    check("short_err", err_short, 1);
    check("short_busy", busy, 1);
    n_ab = 0; n_dn = 0; n_clr = 0;
    for (int i = 0; i < TB_TIMEOUT + 10; i++) begin
      cyc();
      @(negedge clk);
      n_ab += int'(aborted);
      n_dn += int'(done);
      n_clr += int'(dp_clr);
    end
    check("tmo_err", err_timeout, 1);
    check("tmo_aborted_pulses", n_ab, 1);
    check("tmo_clr_pulses", n_clr, 1);
    check("tmo_done_pulses", n_dn, 0);
    check("tmo_short_held", err_short, 1);
    abort = 1;
    cyc();
    @(negedge clk);
    check("idle_abort_ignored", aborted, 0);

    // abort coinciding with the final block
    full_frame(1);

    // async reset during capture
    start_frame(99, 35);
    pixel(0, 0, 0, 0);
    run_blocks(20);
    #2 resetn = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_count", blk_count, 0);
    check("arst_xsize", x_size_m1, 0);
    check("arst_gate", pix_gate, 0);
    check("arst_flags", {done, aborted, dp_clr, err_short, err_timeout}, 0);
    cyc();
    cyc();
    resetn = 1;
    cyc();
    start_frame(99, 35);
    pixel(0, 0, 0, 0);
    pixel(99, 35, 0, 1);
    run_blocks(125);
    last_block(0);
    @(negedge clk);
    check("post_rst_done", done, 1);
    check("post_rst_count", blk_count, 126);
    cyc();

    // random traffic on small frames
    for (int i = 0; i < 8000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 299) == 0);
      x_size_m1_cfg = 10'($urandom_range(0, 63));
      y_size_m1_cfg = 10'($urandom_range(0, 63));
      yuvrgb_in_valid0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        yuvrgb_in_pixel_count = 0;
        yuvrgb_in_line_count = 0;
      end else begin
        yuvrgb_in_pixel_count = 10'($urandom_range(0, 63));
        yuvrgb_in_line_count = 10'($urandom_range(0, 63));
      end
      yuvrgb_in_hold = ($urandom_range(0, 3) == 0);
      eof_in = ($urandom_range(0, 59) == 0);
      di_valid = 1'($urandom_range(0, 1));
      di_hold = ($urandom_range(0, 3) == 0);
      di_cnt = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'($urandom_range(0, 6));
      cyc();
    end
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
